// File: rtl/counter_pkg.sv
// Shared constants and helpers for the up/down modulo counter.
// Counter mode encodings and the load clamp used by updown_mod_counter.
package counter_pkg;

    localparam int CNT_MODE_WRAP = 0;
    localparam int CNT_MODE_SAT  = 1;

    // Out-of-range load values pin to the top of the count range.
    function automatic int unsigned clamp_load(
        input int unsigned val,
        input int unsigned modulus
    );
        return (val >= modulus) ? modulus - 1 : val;
    endfunction

endpackage

// File: rtl/updown_mod_counter_if.sv
// Control and status bundle of the up/down modulo counter.
// master drives control and observes status; slave is the counter.
interface updown_mod_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] c;
    logic             tc;
    logic             wrap;
    logic             sat;

    modport master (
        output en, up, load, load_val,
        input  c, tc, wrap, sat
    );

    modport slave (
        input  en, up, load, load_val,
        output c, tc, wrap, sat
    );
endinterface

// File: rtl/tick_prescaler.sv
// Enable prescaler: one tick every PRESCALE enabled cycles.
// clr restarts the phase; en=0 freezes it.
module tick_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = en && (cnt_q == LAST);

    // Next phase: clear on clr, advance on en, restart after a tick.
    always_comb begin
        cnt_d = cnt_q;
        unique case (1'b1)
            clr:         cnt_d = '0;
            !clr && tick: cnt_d = '0;
            !clr && !tick && en: cnt_d = cnt_q + CW'(1);
            default:     cnt_d = cnt_q;
        endcase
    end

    // Phase register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/updown_mod_counter.sv
// Parametrised up/down modulo counter with wrap/saturate mode,
// parallel load and clock-enable prescaler; registered outputs.
module updown_mod_counter
    import counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int SATURATE = 0,
    parameter int PRESCALE = 1
) (
    input logic clk,
    input logic rst,
    updown_mod_counter_if.slave bus
);
    if (WIDTH < 1 || MODULUS < 2 ||
        64'(MODULUS) > (64'd1 << WIDTH) || PRESCALE < 1 ||
        (SATURATE != CNT_MODE_WRAP && SATURATE != CNT_MODE_SAT))
    begin : g_bad_param
        $error("updown_mod_counter: illegal parameters");
    end

    localparam logic [WIDTH-1:0] MAXV   = WIDTH'(MODULUS - 1);
    localparam bit               SAT_EN = (SATURATE == CNT_MODE_SAT);

    logic [WIDTH-1:0] c_q, c_d;
    logic             wrap_q, wrap_d;
    logic             sat_q, sat_d;
    logic             tick;
    logic             at_end;
    logic [WIDTH-1:0] load_c;

    tick_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_pre (
        .clk (clk),
        .rst (rst),
        .en  (bus.en),
        .clr (bus.load),
        .tick(tick)
    );

    assign at_end = bus.up ? (c_q == MAXV) : (c_q == '0);
    assign load_c = WIDTH'(clamp_load(32'(bus.load_val), MODULUS));

    assign bus.c    = c_q;
    assign bus.tc   = at_end;
    assign bus.wrap = wrap_q;
    assign bus.sat  = sat_q;

    // Next state: load beats step; a step at a range end wraps or blocks.
    always_comb begin
        c_d    = c_q;
        wrap_d = 1'b0;
        sat_d  = sat_q;
        unique case (1'b1)
            bus.load: begin
                c_d   = load_c;
                sat_d = 1'b0;
            end
            !bus.load && tick && !at_end: begin
                c_d   = bus.up ? c_q + WIDTH'(1) : c_q - WIDTH'(1);
                sat_d = 1'b0;
            end
            !bus.load && tick && at_end && SAT_EN: begin
                sat_d = 1'b1;
            end
            !bus.load && tick && at_end && !SAT_EN: begin
                c_d    = bus.up ? '0 : MAXV;
                wrap_d = 1'b1;
            end
            default: begin
                c_d = c_q;
            end
        endcase
    end

    // Count and status registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c_q    <= '0;
            wrap_q <= 1'b0;
            sat_q  <= 1'b0;
        end else begin
            c_q    <= c_d;
            wrap_q <= wrap_d;
            sat_q  <= sat_d;
        end
    end
endmodule

// File: tb/tb_updown_mod_counter.sv
// Scoreboard bench for updown_mod_counter over four configurations.
// Expected state comes from a behavioural model queued at drive time.
module tb_updown_mod_counter;

    typedef struct {
        int c;
        int p;
        bit w;
        bit s;
    } st_t;

    typedef struct {
        int id;
        int c;
        bit w;
        bit s;
        bit tc;
    } exp_t;

    localparam int MODS [4] = '{4, 10, 10, 10};
    localparam int SATS [4] = '{0, 1, 0, 0};
    localparam int PRES [4] = '{1, 1, 3, 1};

    logic clk = 1'b0;
    logic rst = 1'b0;

    int   n_chk  = 0;
    int   n_pass = 0;
    st_t  st [4];
    exp_t sb [$];

    always #5 clk = ~clk;

    updown_mod_counter_if #(.WIDTH(2)) ia ();
    updown_mod_counter_if #(.WIDTH(4)) ib ();
    updown_mod_counter_if #(.WIDTH(4)) ic ();
    updown_mod_counter_if #(.WIDTH(4)) id_ ();

    updown_mod_counter #(
        .WIDTH(2), .MODULUS(4), .SATURATE(0), .PRESCALE(1)
    ) dut_a (.clk(clk), .rst(rst), .bus(ia));

    updown_mod_counter #(
        .WIDTH(4), .MODULUS(10), .SATURATE(1), .PRESCALE(1)
    ) dut_b (.clk(clk), .rst(rst), .bus(ib));

    updown_mod_counter #(
        .WIDTH(4), .MODULUS(10), .SATURATE(0), .PRESCALE(3)
    ) dut_c (.clk(clk), .rst(rst), .bus(ic));

    updown_mod_counter #(
        .WIDTH(4), .MODULUS(10), .SATURATE(0), .PRESCALE(1)
    ) dut_d (.clk(clk), .rst(rst), .bus(id_));

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_chk++;
        if (obs == exp_v) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", tag, obs, exp_v);
    endtask

    function automatic st_t model(
        input st_t s, input int m, input int satm, input int pre,
        input bit en, input bit up, input bit ld, input int lv
    );
        st_t n;
        bit  tk;
        n   = s;
        n.w = 1'b0;
        if (ld) begin
            n.c = (lv >= m) ? m - 1 : lv;
            n.p = 0;
            n.s = 1'b0;
        end else if (en) begin
            tk  = (s.p == pre - 1);
            n.p = tk ? 0 : s.p + 1;
            if (tk) begin
                if (up && s.c < m - 1) begin
                    n.c = s.c + 1; n.s = 1'b0;
                end else if (!up && s.c > 0) begin
                    n.c = s.c - 1; n.s = 1'b0;
                end else if (satm != 0) begin
                    n.s = 1'b1;
                end else begin
                    n.c = up ? 0 : m - 1; n.w = 1'b1;
                end
            end
        end
        return n;
    endfunction

    function automatic int get_c(input int i);
        case (i)
            0: return int'(ia.c);
            1: return int'(ib.c);
            2: return int'(ic.c);
            default: return int'(id_.c);
        endcase
    endfunction

    function automatic logic [3:0] get_flags(input int i);
        case (i)
            0: return {1'b0, ia.tc, ia.wrap, ia.sat};
            1: return {1'b0, ib.tc, ib.wrap, ib.sat};
            2: return {1'b0, ic.tc, ic.wrap, ic.sat};
            default: return {1'b0, id_.tc, id_.wrap, id_.sat};
        endcase
    endfunction

    task automatic drive(
        input int i, input bit en, input bit up, input bit ld, input int lv
    );
        ia.en = 0; ia.load = 0;
        ib.en = 0; ib.load = 0;
        ic.en = 0; ic.load = 0;
        id_.en = 0; id_.load = 0;
        case (i)
            0: begin ia.en = en; ia.up = up; ia.load = ld; ia.load_val = 2'(lv); end
            1: begin ib.en = en; ib.up = up; ib.load = ld; ib.load_val = 4'(lv); end
            2: begin ic.en = en; ic.up = up; ic.load = ld; ic.load_val = 4'(lv); end
            default: begin
                id_.en = en; id_.up = up; id_.load = ld; id_.load_val = 4'(lv);
            end
        endcase
    endtask

    task automatic cycle(
        input int i, input bit en, input bit up,
        input bit ld, input int lv, input string tag
    );
        exp_t       e;
        logic [3:0] f;
        drive(i, en, up, ld, lv);
        for (int k = 0; k < 4; k++) begin
            if (k == i) st[k] = model(st[k], MODS[k], SATS[k], PRES[k], en, up, ld, lv);
            else        st[k] = model(st[k], MODS[k], SATS[k], PRES[k], 0, 0, 0, 0);
        end
        e.id = i;
        e.c  = st[i].c;
        e.w  = st[i].w;
        e.s  = st[i].s;
        e.tc = up ? (st[i].c == MODS[i] - 1) : (st[i].c == 0);
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        f = get_flags(e.id);
        chk({tag, ".c"},    get_c(e.id), e.c);
        chk({tag, ".wrap"}, int'(f[1]),  int'(e.w));
        chk({tag, ".sat"},  int'(f[0]),  int'(e.s));
        chk({tag, ".tc"},   int'(f[2]),  int'(e.tc));
    endtask

    task automatic chk_all_reset(input string tag);
        logic [3:0] f;
        for (int k = 0; k < 4; k++) begin
            f = get_flags(k);
            chk($sformatf("%s.c%0d", tag, k),    get_c(k),   0);
            chk($sformatf("%s.wrap%0d", tag, k), int'(f[1]), 0);
            chk($sformatf("%s.sat%0d", tag, k),  int'(f[0]), 0);
            st[k] = '{c: 0, p: 0, w: 1'b0, s: 1'b0};
        end
    endtask

    initial begin
        ia.up = 1; ib.up = 1; ic.up = 1; id_.up = 1;
        ia.load_val = '0; ib.load_val = '0;
        ic.load_val = '0; id_.load_val = '0;
        drive(0, 0, 1, 0, 0);
        #12;
        chk_all_reset("reset");
        @(negedge clk);
        rst = 1'b1;

        for (int k = 0; k < 5; k++) cycle(0, 1, 1, 0, 0, "a_up");
        cycle(0, 0, 1, 1, 0, "a_ld0");
        for (int k = 0; k < 5; k++) cycle(0, 1, 0, 0, 0, "a_dn");
        cycle(0, 0, 0, 0, 0, "a_hold");

        cycle(1, 0, 1, 1, 7, "b_ld7");
        for (int k = 0; k < 4; k++) cycle(1, 1, 1, 0, 0, "b_up");
        cycle(1, 1, 0, 0, 0, "b_dn");
        cycle(1, 1, 1, 0, 0, "b_up2");
        cycle(1, 1, 1, 0, 0, "b_sat2");
        cycle(1, 0, 1, 0, 0, "b_hold");

        cycle(3, 1, 1, 1, 12, "d_clamp");
        cycle(3, 1, 1, 0, 0, "d_wrap");
        cycle(3, 1, 0, 0, 0, "d_dnwrap");
        cycle(3, 0, 1, 1, 15, "d_clamp15");

        cycle(2, 1, 1, 0, 0, "c_p1");
        cycle(2, 1, 1, 0, 0, "c_p2");
        cycle(2, 0, 1, 0, 0, "c_off1");
        cycle(2, 0, 1, 0, 0, "c_off2");
        cycle(2, 1, 1, 0, 0, "c_tick");
        for (int k = 0; k < 6; k++) cycle(2, 1, 1, 0, 0, "c_run");
        cycle(2, 1, 0, 0, 0, "c_dir");
        cycle(2, 1, 0, 0, 0, "c_dir2");
        cycle(2, 0, 1, 1, 5, "c_ld");
        for (int k = 0; k < 3; k++) cycle(2, 1, 1, 0, 0, "c_after");

        cycle(1, 1, 1, 0, 0, "b_resat");
        cycle(0, 0, 1, 1, 2, "a_ld2");
        #2;
        rst = 1'b0;
        #1;
        chk_all_reset("async");
        @(negedge clk);
        rst = 1'b1;
        cycle(0, 1, 1, 0, 0, "a_resume");
        cycle(0, 1, 1, 0, 0, "a_resume2");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
